uart_fifo_tx: RTL

Buffered UART transmitter. It accepts bytes over a valid/ready handshake into an internal FIFO and serializes them onto the TX line as 8-bit, LSB-first frames: 1 start bit, optional parity bit, 1 stop bit. It drains the FIFO back-to-back with no idle gap between frames. It is the transmit-side companion to the existing UART receive path, and host/firmware logic uses it to stream multi-byte responses without per-byte polling.

---
 rtl/uart_fifo_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: buffered UART transmitter. Bytes enter a small FIFO over a
// valid/ready handshake and leave as LSB-first frames (start, 8 data bits,
// optional parity, stop). Frames are drained back-to-back with no idle gap.
module uart_fifo_tx #(
   parameter logic [23:0] BAUD_RATE  = 24'd9600,
   parameter logic [27:0] CLOCK_FREQ = 28'd100000000,
   parameter int          FIFO_DEPTH = 8,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                        clk_int,
   input  logic                        uart_reset,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        uart_tx_d_out,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               LVL_W    = PTR_W + 1;
   localparam logic [27:0]      DIV      = CLOCK_FREQ / {4'd0, BAUD_RATE};
   localparam logic [15:0]      DIV_M1   = DIV[15:0] - 16'd1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;

   // Serializer state
   state_t           state_reg;
   logic [15:0]      cnt_reg;
   logic [2:0]       bit_idx_reg;
   logic [7:0]       shift_reg;
   logic             parity_reg;
   logic             line_reg;
   logic             busy_reg;

   logic             push_en;
   logic             pop_en;
   logic             fifo_empty;
   logic             bit_done;
   logic [7:0]       head_byte;

   // Ready comes purely from the registered level, so a pop in the same cycle
   // never opens the door for a push into a full FIFO.
   assign fifo_empty = (level_reg == '0);
   assign tx_ready   = (level_reg != LVL_FULL);
   assign push_en    = tx_valid && tx_ready;
   assign bit_done   = (cnt_reg == 16'd0);
   assign head_byte  = mem[rd_ptr_reg];

   // A byte leaves the FIFO either from idle or on the last stop-bit cycle,
   // which is what lets frames run back-to-back.
   assign pop_en = !fifo_empty &&
                   ((state_reg == IDLE) || ((state_reg == STOP) && bit_done));

   assign uart_tx_d_out = line_reg;
   assign tx_busy       = busy_reg;
   assign fifo_level    = level_reg;

   // Storage write port; the array carries no reset so it can map to RAM.
   always_ff @(posedge clk_int) begin
      if (push_en) begin
         mem[wr_ptr_reg] <= tx_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk_int or negedge uart_reset) begin
      if (!uart_reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_en) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (push_en && !pop_en) begin
            level_reg <= level_reg + LVL_W'(1);
         end else if (!push_en && pop_en) begin
            level_reg <= level_reg - LVL_W'(1);
         end
      end
   end

   // Frame sequencer; line and busy are registered and always set one state
   // ahead so every line bit lasts exactly DIV cycles.
   always_ff @(posedge clk_int or negedge uart_reset) begin
      if (!uart_reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         parity_reg  <= 1'b0;
         line_reg    <= 1'b1;
         busy_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               line_reg <= 1'b1;
               busy_reg <= 1'b0;
               if (pop_en) begin
                  shift_reg  <= head_byte;
                  parity_reg <= (^head_byte) ^ PARITY_ODD;
                  cnt_reg    <= DIV_M1;
                  state_reg  <= START;
                  line_reg   <= 1'b0;
                  busy_reg   <= 1'b1;
               end
            end

            START: begin
               if (bit_done) begin
                  cnt_reg     <= DIV_M1;
                  bit_idx_reg <= '0;
                  state_reg   <= DATA;
                  line_reg    <= shift_reg[0];
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end

            DATA: begin
               if (bit_done) begin
                  cnt_reg <= DIV_M1;
                  if (bit_idx_reg == 3'd7) begin
                     if (PARITY_EN) begin
                        state_reg <= PARITY;
                        line_reg  <= parity_reg;
                     end else begin
                        state_reg <= STOP;
                        line_reg  <= 1'b1;
                     end
                  end else begin
                     shift_reg   <= {1'b0, shift_reg[7:1]};
                     line_reg    <= shift_reg[1];
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end

            PARITY: begin
               if (bit_done) begin
                  cnt_reg   <= DIV_M1;
                  state_reg <= STOP;
                  line_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end

            STOP: begin
               if (bit_done) begin
                  if (pop_en) begin
                     shift_reg  <= head_byte;
                     parity_reg <= (^head_byte) ^ PARITY_ODD;
                     cnt_reg    <= DIV_M1;
                     state_reg  <= START;
                     line_reg   <= 1'b0;
                  end else begin
                     state_reg <= IDLE;
                     line_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end

            default: begin
               state_reg <= IDLE;
               line_reg  <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule
